// File: rtl/quacker_pkg.sv
// ============================================================================
// quacker_pkg : register indices, response codes and FSM state types
//               shared by the quacker AXI4-Lite register slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package quacker_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_AUX    = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/quacker_axil_slave.sv
// ============================================================================
// quacker_axil_slave : AXI4-Lite slave holding four 32-bit quacker registers,
//                      with a one-cycle write strobe per committed write.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module quacker_axil_slave
  import quacker_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3,
  output logic [3:0]                      wr_strobe
);

  localparam int c_STRB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_e                     r_wstate;
  rd_state_e                     r_rstate;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
  logic                          r_aw_full;
  logic [1:0]                    r_aw_addr;
  logic                          r_w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
  logic [c_STRB_W-1:0]           r_w_strb;
  logic                          r_awready;
  logic                          r_wready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [3:0]                    r_wr_strobe;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [1:0]                    w_wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [c_STRB_W-1:0]           w_wr_strb;
  logic                          w_unused;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
    input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
    input logic [c_STRB_W-1:0]           strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < c_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID  & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  // Commit on the edge that completes the pair, bypassing whichever buffer is filling now
  assign w_commit  = (r_wstate == W_IDLE) & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[3:2] : r_aw_addr;
  assign w_wr_data = w_w_hs  ? S_AXI_WDATA       : r_w_data;
  assign w_wr_strb = w_w_hs  ? S_AXI_WSTRB       : r_w_strb;
  assign w_unused  = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate    <= W_IDLE;
      r_aw_full   <= 1'b0;
      r_aw_addr   <= '0;
      r_w_full    <= 1'b0;
      r_w_data    <= '0;
      r_w_strb    <= '0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_wr_strobe <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= '0;
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_regs[w_wr_idx] <= merge_bytes(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
            r_wr_strobe      <= 4'b0001 << w_wr_idx;
            r_bvalid         <= 1'b1;
            r_aw_full        <= 1'b0;
            r_w_full         <= 1'b0;
            r_awready        <= 1'b0;
            r_wready         <= 1'b0;
            r_wstate         <= W_RESP;
          end else begin
            if (w_aw_hs) begin
              r_aw_full <= 1'b1;
              r_aw_addr <= S_AXI_AWADDR[3:2];
              r_awready <= 1'b0;
            end else begin
              r_awready <= ~r_aw_full;
            end
            if (w_w_hs) begin
              r_w_full <= 1'b1;
              r_w_data <= S_AXI_WDATA;
              r_w_strb <= S_AXI_WSTRB;
              r_wready <= 1'b0;
            end else begin
              r_wready <= ~r_w_full;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Reads sample the registers before any same-edge write lands
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= r_regs[S_AXI_ARADDR[3:2]];
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = r_rvalid;
  assign reg0          = r_regs[REG_CTRL];
  assign reg1          = r_regs[REG_PERIOD];
  assign reg2          = r_regs[REG_DUTY];
  assign reg3          = r_regs[REG_AUX];
  assign wr_strobe     = r_wr_strobe;

endmodule

`default_nettype wire

// File: tb/tb_quacker_axil_slave.sv
// ============================================================================
// tb_quacker_axil_slave : directed scoreboard bench for quacker_axil_slave.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_quacker_axil_slave;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic [3:0]  tb_AWADDR = '0;
  logic [2:0]  tb_AWPROT = '0;
  logic        tb_AWVALID = 1'b0;
  logic        tb_AWREADY;
  logic [31:0] tb_WDATA = '0;
  logic [3:0]  tb_WSTRB = '0;
  logic        tb_WVALID = 1'b0;
  logic        tb_WREADY;
  logic [1:0]  tb_BRESP;
  logic        tb_BVALID;
  logic        tb_BREADY = 1'b1;
  logic [3:0]  tb_ARADDR = '0;
  logic [2:0]  tb_ARPROT = '0;
  logic        tb_ARVALID = 1'b0;
  logic        tb_ARREADY;
  logic [31:0] tb_RDATA;
  logic [1:0]  tb_RRESP;
  logic        tb_RVALID;
  logic        tb_RREADY = 1'b1;
  logic [31:0] tb_reg0, tb_reg1, tb_reg2, tb_reg3;
  logic [3:0]  tb_wr_strobe;

  always #5 tb_ACLK = ~tb_ACLK;

  quacker_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .S_AXI_AWADDR(tb_AWADDR), .S_AXI_AWPROT(tb_AWPROT), .S_AXI_AWVALID(tb_AWVALID),
    .S_AXI_AWREADY(tb_AWREADY),
    .S_AXI_WDATA(tb_WDATA), .S_AXI_WSTRB(tb_WSTRB), .S_AXI_WVALID(tb_WVALID),
    .S_AXI_WREADY(tb_WREADY),
    .S_AXI_BRESP(tb_BRESP), .S_AXI_BVALID(tb_BVALID), .S_AXI_BREADY(tb_BREADY),
    .S_AXI_ARADDR(tb_ARADDR), .S_AXI_ARPROT(tb_ARPROT), .S_AXI_ARVALID(tb_ARVALID),
    .S_AXI_ARREADY(tb_ARREADY),
    .S_AXI_RDATA(tb_RDATA), .S_AXI_RRESP(tb_RRESP), .S_AXI_RVALID(tb_RVALID),
    .S_AXI_RREADY(tb_RREADY),
    .reg0(tb_reg0), .reg1(tb_reg1), .reg2(tb_reg2), .reg3(tb_reg3),
    .wr_strobe(tb_wr_strobe)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_regs [4];
  logic [31:0] rd_q [$];
  logic [5:0]  wr_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  // mode 0: AW and W together, 1: W then AW after 2 idle cycles, 2: AW then W after 3 idle cycles
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode);
    bit         aw_done, w_done, aw_fire, w_fire;
    int         t, g, gap;
    logic [1:0] idx;
    logic [5:0] exp;
    idx = addr[3:2];
    for (int b = 0; b < 4; b++)
      if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
    wr_q.push_back({2'b00, 4'b0001 << idx});
    tb_AWADDR = addr[3:0];
    tb_WDATA  = data;
    tb_WSTRB  = strb;
    aw_done = 0; w_done = 0; g = 0; t = 0;
    gap = (mode == 1) ? 2 : 3;
    if (mode != 2) tb_WVALID  = 1'b1;
    if (mode != 1) tb_AWVALID = 1'b1;
    while (!(aw_done && w_done) && t < 50) begin
      aw_fire = tb_AWVALID && tb_AWREADY;
      w_fire  = tb_WVALID && tb_WREADY;
      tick();
      t++;
      if (aw_fire) begin tb_AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin tb_WVALID  = 1'b0; w_done  = 1; end
      if (mode == 1 && w_done && !aw_done && !tb_AWVALID) begin
        if (g == gap) tb_AWVALID = 1'b1; else g++;
      end
      if (mode == 2 && aw_done && !w_done && !tb_WVALID) begin
        if (g == gap) tb_WVALID = 1'b1; else g++;
      end
    end
    tb_AWVALID = 1'b0;
    tb_WVALID  = 1'b0;
    check("wr_handshake_done", {31'd0, aw_done && w_done}, 32'd1);
    t = 0;
    while (!tb_BVALID && t < 20) begin tick(); t++; end
    check("wr_bvalid_latency", t, 32'd0);
    exp = wr_q.pop_front();
    check("wr_bresp", {30'd0, tb_BRESP}, {30'd0, exp[5:4]});
    check("wr_strobe", {28'd0, tb_wr_strobe}, {28'd0, exp[3:0]});
    if (tb_BREADY) begin
      tick();
      check("wr_bvalid_drop", {31'd0, tb_BVALID}, 32'd0);
      check("wr_strobe_pulse", {28'd0, tb_wr_strobe}, 32'd0);
      tick();
      tick();
      check("wr_single_bvalid", {31'd0, tb_BVALID}, 32'd0);
    end
  endtask

  task automatic axi_read(input logic [7:0] addr);
    int          t;
    bit          fire;
    logic [31:0] exp;
    rd_q.push_back(m_regs[addr[3:2]]);
    tb_ARADDR  = addr[3:0];
    tb_ARVALID = 1'b1;
    t = 0;
    fire = 0;
    while (!fire && t < 50) begin
      fire = tb_ARVALID && tb_ARREADY;
      tick();
      t++;
    end
    tb_ARVALID = 1'b0;
    check("rd_ar_handshake", {31'd0, fire}, 32'd1);
    t = 0;
    while (!tb_RVALID && t < 20) begin tick(); t++; end
    check("rd_latency", t, 32'd0);
    exp = rd_q.pop_front();
    check("rd_data", tb_RDATA, exp);
    check("rd_rresp", {30'd0, tb_RRESP}, 32'd0);
    if (tb_RREADY) begin
      tick();
      check("rd_rvalid_drop", {31'd0, tb_RVALID}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok_valid, ok_data, ok_ready, ok_nocommit;
    logic [31:0] held_rdata;
    bit          fire;
    int          t;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;

    // Reset
    #490;
    check("rst_handshake_outs",
          {20'd0, tb_AWREADY, tb_WREADY, tb_BVALID, tb_ARREADY, tb_RVALID, tb_wr_strobe, tb_BRESP, tb_RRESP},
          32'd0);
    check("rst_rdata", tb_RDATA, 32'd0);
    check("rst_regs", tb_reg0 | tb_reg1 | tb_reg2 | tb_reg3, 32'd0);
    #15;
    @(posedge tb_ACLK);
    #1 tb_ARESETN = 1'b1;
    tick();
    check("rst_ready_first_cycle", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd7);

    // Sequential write / read
    axi_write(8'h0, 32'h0101FFFF, 4'hF, 0);
    axi_write(8'h4, 32'habcd0001, 4'hF, 0);
    axi_write(8'h8, 32'hdead0011, 4'hF, 0);
    axi_write(8'hC, 32'hbeef0011, 4'hF, 0);
    axi_read(8'h0);
    axi_read(8'h4);
    axi_read(8'h8);
    axi_read(8'hC);
    check("reg_outputs_seq", tb_reg3, 32'hbeef0011);

    // Channel ordering
    axi_write(8'h4, 32'h12345678, 4'hF, 1);
    axi_read(8'h4);
    axi_write(8'h4, 32'h12345678, 4'hF, 2);
    axi_read(8'h4);
    axi_write(8'h4, 32'h12345678, 4'hF, 0);
    axi_read(8'h4);
    check("reg1_after_orders", tb_reg1, 32'h12345678);

    // Byte strobes
    axi_write(8'h8, 32'hFFFFFFFF, 4'b0101, 0);
    axi_read(8'h8);
    check("strb_0101_reg2", tb_reg2, 32'hdeFF00FF);
    axi_write(8'h8, 32'h00000000, 4'b0000, 0);
    axi_read(8'h8);
    check("strb_0000_reg2", tb_reg2, 32'hdeFF00FF);

    // Backpressure on both response channels
    tb_BREADY = 1'b0;
    axi_write(8'hC, 32'h55AA55AA, 4'hF, 0);
    tb_RREADY = 1'b0;
    axi_read(8'h4);
    held_rdata = tb_RDATA;
    tb_AWADDR = 4'hC; tb_WDATA = 32'h11111111; tb_WSTRB = 4'hF;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1;
    tb_ARADDR = 4'h0; tb_ARVALID = 1'b1;
    ok_valid = 1; ok_data = 1; ok_ready = 1; ok_nocommit = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!(tb_BVALID && tb_RVALID && tb_BRESP == 2'b00)) ok_valid = 0;
      if (tb_RDATA !== held_rdata) ok_data = 0;
      if (tb_AWREADY || tb_WREADY || tb_ARREADY) ok_ready = 0;
      if (tb_wr_strobe != 4'd0 || tb_reg3 !== 32'h55AA55AA) ok_nocommit = 0;
    end
    check("bp_valids_held", {31'd0, ok_valid}, 32'd1);
    check("bp_rdata_stable", {31'd0, ok_data}, 32'd1);
    check("bp_readies_low", {31'd0, ok_ready}, 32'd1);
    check("bp_no_second_commit", {31'd0, ok_nocommit}, 32'd1);
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0; tb_ARVALID = 1'b0;
    tb_BREADY = 1'b1; tb_RREADY = 1'b1;
    tick();
    check("bp_release", {30'd0, tb_BVALID, tb_RVALID}, 32'd0);
    tick();
    check("bp_reg3_final", tb_reg3, 32'h55AA55AA);

    // Reset in the middle of a write
    tb_AWADDR = 4'h8; tb_AWVALID = 1'b1;
    t = 0; fire = 0;
    while (!fire && t < 20) begin
      fire = tb_AWVALID && tb_AWREADY;
      tick();
      t++;
    end
    tb_AWVALID = 1'b0;
    check("mid_aw_accepted", {31'd0, fire}, 32'd1);
    tb_ARESETN = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    tick();
    tick();
    tb_ARESETN = 1'b1;
    tick();
    tick();
    check("mid_rst_regs", tb_reg0 | tb_reg1 | tb_reg2 | tb_reg3, 32'd0);
    check("mid_rst_no_bvalid", {31'd0, tb_BVALID}, 32'd0);
    axi_write(8'h4, 32'hCAFEF00D, 4'hF, 1);
    axi_read(8'h4);

    // Address aliasing
    axi_write(8'h10, 32'h0BADBEEF, 4'hF, 0);
    check("alias_reg0", tb_reg0, 32'h0BADBEEF);
    axi_read(8'h3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
